// File: rtl/controlador_cambio.sv
// Change dispenser: greedily pays out owed change in 5/2/1-unit coins through a
// request/acknowledge coin ejector, tracking per-denomination stock.
module controlador_cambio #(
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned STOCK_INIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cambio_valid,
  input  logic [3:0] cambio,
  input  logic       refill,
  input  logic       eject_ack,
  output logic       eject_req,
  output logic [1:0] eject_coin,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] pendiente,
  output logic [3:0] stock1,
  output logic [3:0] stock2,
  output logic [3:0] stock5
);

  localparam int unsigned CW        = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [3:0] STOCK_RST  = 4'(STOCK_INIT);
  localparam logic [1:0] COIN_NONE  = 2'b00;
  localparam logic [1:0] COIN_1     = 2'b01;
  localparam logic [1:0] COIN_2     = 2'b10;
  localparam logic [1:0] COIN_5     = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    EJECT  = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;

  // Outputs are registered alongside the state: each transition sets the
  // outputs that belong to the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      eject_req  <= 1'b0;
      eject_coin <= COIN_NONE;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      pendiente  <= '0;
      stock1     <= STOCK_RST;
      stock2     <= STOCK_RST;
      stock5     <= STOCK_RST;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (refill) begin
            stock1 <= STOCK_RST;
            stock2 <= STOCK_RST;
            stock5 <= STOCK_RST;
          end
          if (cambio_valid) begin
            pendiente <= cambio;
            busy      <= 1'b1;
            state     <= SELECT;
          end
        end

        // Largest coin that fits the remaining amount and is still in stock
        SELECT: begin
          if (pendiente == 4'd0) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (pendiente >= 4'd5 && stock5 != 4'd0) begin
            eject_req  <= 1'b1;
            eject_coin <= COIN_5;
            cnt        <= '0;
            state      <= EJECT;
          end else if (pendiente >= 4'd2 && stock2 != 4'd0) begin
            eject_req  <= 1'b1;
            eject_coin <= COIN_2;
            cnt        <= '0;
            state      <= EJECT;
          end else if (stock1 != 4'd0) begin
            eject_req  <= 1'b1;
            eject_coin <= COIN_1;
            cnt        <= '0;
            state      <= EJECT;
          end else begin
            error <= 1'b1;
            state <= ERROR;
          end
        end

        // An acknowledge on the final wait cycle still counts as delivered
        EJECT: begin
          if (eject_ack) begin
            case (eject_coin)
              COIN_5: begin
                pendiente <= pendiente - 4'd5;
                stock5    <= stock5 - 4'd1;
              end
              COIN_2: begin
                pendiente <= pendiente - 4'd2;
                stock2    <= stock2 - 4'd1;
              end
              COIN_1: begin
                pendiente <= pendiente - 4'd1;
                stock1    <= stock1 - 4'd1;
              end
              default: ;
            endcase
            eject_req  <= 1'b0;
            eject_coin <= COIN_NONE;
            state      <= GAP;
          end else if (cnt == CNT_LAST) begin
            eject_req  <= 1'b0;
            eject_coin <= COIN_NONE;
            error      <= 1'b1;
            state      <= ERROR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        GAP: state <= SELECT;

        DONE, ERROR: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          eject_req  <= 1'b0;
          eject_coin <= COIN_NONE;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_cambio.sv
// Bench for controlador_cambio: table of transactions plus hand-built sequences;
// expected coins go into a scoreboard queue and are popped as the ejector accepts them.
module tb_controlador_cambio;

  localparam int unsigned TO    = 20;
  localparam int          NEVER = 255;

  logic       clk = 1'b0;
  logic       reset, cambio_valid, refill, eject_ack;
  logic [3:0] cambio;
  logic       eject_req, busy, done, error;
  logic [1:0] eject_coin;
  logic [3:0] pendiente, stock1, stock2, stock5;

  controlador_cambio #(.TIMEOUT(TO), .STOCK_INIT(15)) dut (
    .clk(clk), .reset(reset), .cambio_valid(cambio_valid), .cambio(cambio),
    .refill(refill), .eject_ack(eject_ack), .eject_req(eject_req),
    .eject_coin(eject_coin), .busy(busy), .done(done), .error(error),
    .pendiente(pendiente), .stock1(stock1), .stock2(stock2), .stock5(stock5)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cambio;
    logic       refill;
    int         ack_delay;
    logic       stray;
    int         ncoins;
    logic [7:0] coins;
    logic       exp_err;
    logic [3:0] pend;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] s5;
  } vec_t;

  int         n_pass = 0;
  int         n_total = 0;
  logic [1:0] sb_q[$];
  vec_t       tbl[6];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] c, input logic r, input int d,
                              input logic st, input int n, input logic [7:0] cs,
                              input logic e, input logic [3:0] p, input logic [3:0] s1,
                              input logic [3:0] s2, input logic [3:0] s5);
    vec_t v;
    v.cambio = c; v.refill = r; v.ack_delay = d; v.stray = st; v.ncoins = n;
    v.coins = cs; v.exp_err = e; v.pend = p; v.s1 = s1; v.s2 = s2; v.s5 = s5;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int         req_cnt, req_tot, first_req, end_cyc;
    logic [1:0] cur, exp_coin;
    logic       fin, got_done, got_err;
    for (int i = 0; i < v.ncoins; i++) sb_q.push_back(v.coins[2*i +: 2]);
    @(negedge clk);
    cambio = v.cambio; cambio_valid = 1'b1; refill = v.refill; eject_ack = 1'b0;
    req_cnt = 0; req_tot = 0; first_req = 0; end_cyc = 0;
    fin = 1'b0; got_done = 1'b0; got_err = 1'b0; cur = 2'b00;
    for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
      @(negedge clk);
      cambio_valid = 1'b0; refill = 1'b0; eject_ack = 1'b0;
      if (cyc == 1) begin
        chk({nm, " busy_select"}, int'(busy), 1);
        chk({nm, " pend_latched"}, int'(pendiente), int'(v.cambio));
      end
      if (done || error) begin
        got_done = done; got_err = error; end_cyc = cyc; fin = 1'b1;
        chk({nm, " busy_end"}, int'(busy), 1);
      end else if (eject_req) begin
        req_cnt++; req_tot++;
        if (first_req == 0) first_req = cyc;
        if (req_cnt == 1) cur = eject_coin;
        else chk({nm, " coin_stable"}, int'(eject_coin), int'(cur));
        if (v.ack_delay != NEVER && req_cnt == v.ack_delay + 1) begin
          eject_ack = 1'b1;
          exp_coin = (sb_q.size() > 0) ? sb_q.pop_front() : 2'b00;
          chk({nm, " coin"}, int'(eject_coin), int'(exp_coin));
        end
      end else begin
        req_cnt = 0;
        chk({nm, " coin_idle"}, int'(eject_coin), 0);
        if (v.stray) eject_ack = 1'b1;
      end
    end
    eject_ack = 1'b0;
    chk({nm, " finished"}, int'(fin), 1);
    chk({nm, " done"}, int'(got_done), int'(!v.exp_err));
    chk({nm, " error"}, int'(got_err), int'(v.exp_err));
    if (first_req != 0) chk({nm, " first_req_cyc"}, first_req, 2);
    if (v.cambio == 4'd0) chk({nm, " done_cyc"}, end_cyc, 2);
    if (v.ack_delay == NEVER) chk({nm, " timeout_len"}, req_tot, int'(TO));
    chk({nm, " coins_left"}, sb_q.size(), 0);
    sb_q.delete();
    @(negedge clk);
    chk({nm, " done_pulse"}, int'(done), 0);
    chk({nm, " error_pulse"}, int'(error), 0);
    chk({nm, " busy_idle"}, int'(busy), 0);
    chk({nm, " pend"}, int'(pendiente), int'(v.pend));
    chk({nm, " stock1"}, int'(stock1), int'(v.s1));
    chk({nm, " stock2"}, int'(stock2), int'(v.s2));
    chk({nm, " stock5"}, int'(stock5), int'(v.s5));
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, " req"}, int'(eject_req), 0);
    chk({nm, " coin"}, int'(eject_coin), 0);
    chk({nm, " busy"}, int'(busy), 0);
    chk({nm, " done"}, int'(done), 0);
    chk({nm, " error"}, int'(error), 0);
    chk({nm, " pend"}, int'(pendiente), 0);
    chk({nm, " stocks"}, int'({stock1, stock2, stock5}), int'(12'hFFF));
  endtask

  initial begin
    int waited;
    reset = 1'b1; cambio_valid = 1'b0; cambio = 4'd0; refill = 1'b0; eject_ack = 1'b0;

    //            cambio refill delay stray n  coins         err pend s1  s2  s5
    tbl[0] = mk(4'd8,  1'b0, 2,    1'b0, 3, 8'b00_01_10_11, 1'b0, 4'd0, 4'd14, 4'd14, 4'd14);
    tbl[1] = mk(4'd0,  1'b0, 0,    1'b0, 0, 8'b0,           1'b0, 4'd0, 4'd14, 4'd14, 4'd14);
    tbl[2] = mk(4'd15, 1'b1, 1,    1'b1, 3, 8'b00_11_11_11, 1'b0, 4'd0, 4'd15, 4'd15, 4'd12);
    tbl[3] = mk(4'd9,  1'b0, 1,    1'b0, 3, 8'b00_10_10_11, 1'b0, 4'd0, 4'd15, 4'd13, 4'd11);
    tbl[4] = mk(4'd5,  1'b0, NEVER,1'b0, 0, 8'b0,           1'b1, 4'd5, 4'd15, 4'd13, 4'd11);
    tbl[5] = mk(4'd12, 1'b0, 3,    1'b0, 3, 8'b00_10_11_11, 1'b0, 4'd0, 4'd15, 4'd12, 4'd9);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("init");

    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Drain 1-unit coins, then owe 3: one 2-unit coin, then no way to pay the last unit
    run_vec(mk(4'd1, 1'b1, 0, 1'b0, 1, 8'b01, 1'b0, 4'd0, 4'd14, 4'd15, 4'd15), "drain1_first");
    for (int i = 0; i < 14; i++)
      run_vec(mk(4'd1, 1'b0, 0, 1'b0, 1, 8'b01, 1'b0, 4'd0, 4'(13 - i), 4'd15, 4'd15), "drain1");
    run_vec(mk(4'd3, 1'b0, 0, 1'b0, 1, 8'b10, 1'b1, 4'd1, 4'd0, 4'd14, 4'd15), "no_ones");

    // Drain 2-unit coins, then refill together with a request for 2
    for (int i = 0; i < 7; i++)
      run_vec(mk(4'd4, 1'b0, 0, 1'b0, 2, 8'b10_10, 1'b0, 4'd0, 4'd0, 4'(12 - 2*i), 4'd15), "drain2");
    run_vec(mk(4'd2, 1'b0, 0, 1'b0, 0, 8'b0, 1'b1, 4'd2, 4'd0, 4'd0, 4'd15), "empty_err");
    run_vec(mk(4'd2, 1'b1, 0, 1'b0, 1, 8'b10, 1'b0, 4'd0, 4'd15, 4'd14, 4'd15), "refill_go");

    // Reset while a coin is being requested, with ack/refill/valid also high
    @(negedge clk);
    cambio = 4'd7; cambio_valid = 1'b1;
    @(negedge clk);
    cambio_valid = 1'b0;
    waited = 0;
    while (!eject_req && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("mid_reset req_seen", int'(eject_req), 1);
    reset = 1'b1; eject_ack = 1'b1; refill = 1'b1; cambio_valid = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    reset = 1'b0; eject_ack = 1'b0; refill = 1'b0; cambio_valid = 1'b0;
    @(negedge clk);
    chk("post_reset busy", int'(busy), 0);
    run_vec(mk(4'd6, 1'b0, 0, 1'b0, 2, 8'b01_11, 1'b0, 4'd0, 4'd14, 4'd15, 4'd14), "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/controlador_cambio.md
CONTROLADOR_CAMBIO -- requirements
Module: controlador_cambio

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; parameters and ports SHALL be as listed below.
REQ-002 Parameter: TIMEOUT, 255, maximum cycles eject_req may wait for eject_ack (1..255).
REQ-003 Parameter: STOCK_INIT, 15, per-denomination coin count loaded by reset and refill (0..15).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cambio_valid  input  1  one-cycle strobe: cambio holds change owed.
REQ-007 cambio  input  4  change owed, in coin units (0..15).
REQ-008 refill  input  1  reload all coin stocks to STOCK_INIT.
REQ-009 eject_ack  input  1  coin ejector has released the requested coin.
REQ-010 eject_req  output  1  request ejection of one coin.
REQ-011 eject_coin  output  2  denomination requested: 01=1 unit, 10=2 units, 11=5 units, 00=none.
REQ-012 busy  output  1  transaction in progress (state not IDLE).
REQ-013 done  output  1  one-cycle pulse: full change dispensed.
REQ-014 error  output  1  one-cycle pulse: dispensing aborted.
REQ-015 pendiente  output  4  change still owed.
REQ-016 stock1, stock2, stock5  output  4 each  remaining coins per denomination.

Function
REQ-017 States SHALL be IDLE, SELECT, EJECT, GAP, DONE, ERROR, encoded as a single state register.
REQ-018 IDLE: cambio_valid=1 SHALL latch pendiente<=cambio and go to SELECT; cambio_valid outside IDLE SHALL be ignored.
REQ-019 SELECT (one cycle): pendiente=0 -> DONE; else pick largest d in {5,2,1} with d<=pendiente and stock_d>0 -> EJECT; none -> ERROR.
REQ-020 EJECT: eject_req=1 and eject_coin=code(d) held stable, constant every cycle until eject_ack is sampled high.
REQ-021 On eject_ack=1 in EJECT: pendiente<=pendiente-d, stock_d<=stock_d-1, go to GAP; eject_req SHALL be 0 in GAP.
REQ-022 GAP (one cycle): go to SELECT; guarantees eject_req low at least one cycle between coins.
REQ-023 eject_ack outside EJECT SHALL be ignored.
REQ-024 Ack timeout: cycle counter cleared on entry to EJECT; if TIMEOUT cycles elapse without eject_ack, go to ERROR with pendiente and stocks unchanged.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE; ERROR: error=1 for exactly one cycle, then IDLE; pendiente SHALL hold its value until next latch.
REQ-026 Latency: cambio_valid at edge k -> SELECT at k+1 -> eject_req high from k+2; cambio=0 -> done high in cycle k+2.
REQ-027 refill SHALL load stock1, stock2, stock5 to STOCK_INIT only in IDLE; ignored elsewhere.
REQ-028 refill and cambio_valid together in IDLE: refill applies first; transaction uses refilled stocks.
REQ-029 Stock counters SHALL never wrap: decrement only via REQ-021, which requires stock_d>0.
REQ-030 eject_coin SHALL be 00 in every state except EJECT.
REQ-031 busy=1 in every state except IDLE, including DONE and ERROR.

Reset
REQ-032 reset=1 SHALL force, on next edge and regardless of state: IDLE, eject_req=0, eject_coin=00, busy=0, done=0, error=0, pendiente=0, counter=0, stock1=stock2=stock5=STOCK_INIT.
REQ-033 reset mid-EJECT SHALL abandon the transaction without decrementing any stock; reset overrides refill and cambio_valid.

Verification
REQ-034 cambio=8, full stocks, ack 2 cycles after each req -> coins 11,10,01 in order; done pulse; stock5=14, stock2=14, stock1=14; pendiente=0.
REQ-035 cambio=0 -> no eject_req; done high in cycle k+2; stocks unchanged.
REQ-036 stock1=0, stock2=15, stock5=15, cambio=3 -> one coin 10, then error pulse; pendiente=1; stock2=14.
REQ-037 cambio=5, eject_ack never asserted -> eject_req high for TIMEOUT cycles, then error; pendiente=5; stock5 unchanged.
REQ-038 reset asserted while eject_req=1 for cambio=7 -> next cycle IDLE, all outputs at reset values, stocks=15.
REQ-039 refill and cambio_valid (cambio=2) together in IDLE with stock2=0 -> stocks reload to 15, coin 10 dispensed, done; stock2=14.
